csa_multiword_sequencer: RTL
============================

// Module: csa_multiword_sequencer
// PURPOSE
//  Multi-cycle wide add/subtract controller built around one shared 16-bit carry-select adder slice.
//  Accepts a WORDS*16-bit operation over a valid/ready handshake.
//  Feeds the slice one 16-bit word per cycle, LSW first, and registers the carry between cycles.
//  Presents the full result, carry and signed overflow over a valid/ready handshake.
//  Sits between the ALU issue logic and result writeback. Every wide add in the datapath reuses the single slice.
// PARAMETERS
//  WORDS   4   number of 16-bit slices per operation (legal range 1..16); operand width = 16*WORDS
// PORTS
//  clk        in   1          single clock, rising edge
//  rst_n      in   1          asynchronous active-low reset
//  in_valid   in   1          request valid
//  in_ready   out  1          block can accept a request
//  a_in       in   16*WORDS   operand A
//  b_in       in   16*WORDS   operand B
//  sub        in   1          1 = A - B, 0 = A + B
//  cin        in   1          carry-in for add; ignored when sub=1
//  out_valid  out  1          result valid
//  out_ready  in   1          consumer accepts result
//  sum        out  16*WORDS   result
//  cout       out  1          carry out of MSB; for sub, 1 = no borrow
//  overflow   out  1          two's-complement signed overflow
//  busy       out  1          high in RUN or DONE
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - state=IDLE; idx=0; carry=0; sum=0, cout=0, overflow=0, out_valid=0, busy=0.
//   - Internal A/B/sub registers are cleared.
//   - Reset mid-RUN or in DONE aborts the operation; the result is discarded and not presented.
//  FSM: IDLE -> RUN -> DONE -> IDLE.
//   - in_ready = (state==IDLE). It is combinational from state only.
//   - Transfers are only effective on a clock edge with rst_n=1.
//  IDLE
//   - On a clock edge with in_valid && in_ready: capture a_in, b_in and sub.
//   - b_eff = sub ? ~b_in : b_in.
//   - Carry register loads (sub ? 1 : cin); idx=0; go to RUN.
//  RUN
//   - Slice inputs: A = a_reg[16*idx +: 16], B = b_eff[16*idx +: 16], Cin = carry.
//   - On each edge: sum[16*idx +: 16] <= slice S; carry <= slice Cout; idx++.
//   - When idx==WORDS-1: cout <= slice Cout.
//   - Also when idx==WORDS-1: overflow <= (a_msb==beff_msb) && (S_msb!=a_msb). Then go to DONE; idx=0.
//   - Inputs are not sampled in RUN; in_valid is ignored.
//   - Slice inputs are driven with 0 outside RUN.
//  DONE
//   - out_valid=1. sum, cout and overflow are held stable until out_valid && out_ready.
//   - On that edge: out_valid=0, go to IDLE.
//   - sum, cout and overflow keep their values until the next operation completes.
//  Latency and throughput
//   - Accept at edge k -> out_valid high after edge k+WORDS.
//   - Minimum issue interval is WORDS+2 cycles: IDLE, WORDS x RUN, DONE.
//   - No new request is accepted in the cycle DONE completes; it is accepted the following cycle.
//  WORDS=1: RUN lasts one cycle and computes one slice, with identical flag rules.
//  Widths: idx is $clog2(WORDS) bits, minimum 1.
//   - The carry chain wraps only through the registered carry. No truncation beyond 16*WORDS bits.
//  Simultaneous events
//   - out_ready asserted while not out_valid: ignored.
//   - in_valid held high through DONE: accepted once, in IDLE only.
// TESTING
//  1 Assert rst_n=0 -> out_valid=0, sum=0, busy=0, in_ready=1; release -> IDLE.
//  2 Add A=0xFFFF_FFFF_FFFF_FFFF, B=1, cin=0 -> sum=0, cout=1, overflow=0; out_valid 4 cycles after accept.
//  3 Sub A=5, B=7 -> sum=0xFFFF_FFFF_FFFF_FFFE, cout=0 (borrow), overflow=0.
//  4 Add A=0x7FFF_FFFF_FFFF_FFFF, B=1 -> sum=0x8000_0000_0000_0000, overflow=1, cout=0.
//  5 Hold out_ready=0 for 10 cycles in DONE with in_valid=1 -> outputs stable, in_ready=0, no second capture.
//    Then release out_ready -> the next request is accepted the cycle after.
//  6 Drop rst_n in 2nd RUN cycle -> outputs 0 immediately; after release, add 0x1234+0x0001 -> sum=0x1235.

Source files
------------

// File: rtl/csa_multiword_sequencer_if.sv
// csa_multiword_sequencer_if: request/result handshake bundle for the multiword add/sub sequencer
interface csa_multiword_sequencer_if #(parameter int WORDS = 4);
  logic                  in_valid;
  logic                  in_ready;
  logic [16*WORDS-1:0]   a_in;
  logic [16*WORDS-1:0]   b_in;
  logic                  sub;
  logic                  cin;
  logic                  out_valid;
  logic                  out_ready;
  logic [16*WORDS-1:0]   sum;
  logic                  cout;
  logic                  overflow;
  logic                  busy;
  modport master (output in_valid, a_in, b_in, sub, cin, out_ready,
                  input  in_ready, out_valid, sum, cout, overflow, busy);
  modport slave  (input  in_valid, a_in, b_in, sub, cin, out_ready,
                  output in_ready, out_valid, sum, cout, overflow, busy);
endinterface

// File: rtl/csa_multiword_sequencer.sv
// csa_multiword_sequencer: wide add/sub computed one 16-bit word per cycle through a shared carry-select slice
module csa_multiword_sequencer #(
  parameter int WORDS = 4
) (
  input  logic clk,
  input  logic rst_n,
  csa_multiword_sequencer_if.slave bus
);
  localparam int W  = 16 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t          state_q, state_d;
  logic [IW-1:0]   idx;
  logic            carry;
  logic [W-1:0]    a_reg, b_reg;
  logic [W-1:0]    sum_q;
  logic            cout_q, overflow_q;
  logic            run, last, accept;
  logic [15:0]     sl_a, sl_b, sl_s;
  logic            sl_ci, sl_co, c;
  logic [4:0]      r0, r1;
  assign run    = state_q == RUN;
  assign last   = idx == IW'(WORDS - 1);
  assign accept = state_q == IDLE && bus.in_valid;
  assign sl_a   = run ? a_reg[16*idx +: 16] : 16'h0;
  assign sl_b   = run ? b_reg[16*idx +: 16] : 16'h0;
  assign sl_ci  = run ? carry : 1'b0;
  // 4-bit blocks precompute both carry-in cases and the incoming carry selects
  always_comb begin
    c    = sl_ci;
    sl_s = '0;
    r0   = '0;
    r1   = '0;
    for (int i = 0; i < 4; i++) begin
      r0 = {1'b0, sl_a[4*i +: 4]} + {1'b0, sl_b[4*i +: 4]};
      r1 = r0 + 5'd1;
      sl_s[4*i +: 4] = c ? r1[3:0] : r0[3:0];
      c = c ? r1[4] : r0[4];
    end
    sl_co = c;
  end
  always_comb begin
    state_d       = accept ? RUN :
                    (run && last) ? DONE :
                    (state_q == DONE && bus.out_ready) ? IDLE : state_q;
    bus.in_ready  = state_q == IDLE;
    bus.out_valid = state_q == DONE;
    bus.busy      = state_q != IDLE;
  end
  // B is stored already inverted for subtract so RUN only ever adds
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx        <= '0;
      carry      <= 1'b0;
      a_reg      <= '0;
      b_reg      <= '0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_reg <= bus.a_in;
        b_reg <= bus.sub ? ~bus.b_in : bus.b_in;
        carry <= bus.sub | bus.cin;
        idx   <= '0;
      end
      if (run) begin
        sum_q[16*idx +: 16] <= sl_s;
        carry               <= sl_co;
        idx                 <= last ? '0 : idx + 1'b1;
        if (last) begin
          cout_q     <= sl_co;
          overflow_q <= (a_reg[W-1] == b_reg[W-1]) && (sl_s[15] != a_reg[W-1]);
        end
      end
    end
  end
  assign bus.sum      = sum_q;
  assign bus.cout     = cout_q;
  assign bus.overflow = overflow_q;
endmodule
